// File: rtl/riscv_pipeline_interlock_pkg.sv
// Shared types for the pipeline interlock: latency classes and dmem handshake states.
package riscv_pipeline_interlock_pkg;

  typedef enum logic [1:0] {
    LAT_ALU   = 2'd0,
    LAT_LOAD  = 2'd1,
    LAT_MULTI = 2'd2
  } lat_class_t;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_REQ  = 2'd1,
    DM_WAIT = 2'd2
  } dmem_fsm_t;

  function automatic int unsigned max_int(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/riscv_scoreboard.sv
// Per-register result-latency scoreboard: loads a countdown on issue and reports busy sources.
module riscv_scoreboard
  import riscv_pipeline_interlock_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned MULTI_LATENCY = 3,
  parameter int unsigned CNT_W         = $clog2(max_int(LOAD_LATENCY, MULTI_LATENCY) + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       issue,
  input  logic       reg_write,
  input  logic [4:0] rd,
  input  lat_class_t lat_class,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  output logic       busy_rs1,
  output logic       busy_rs2
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [CNT_W-1:0] issue_lat;

  always_comb begin
    case (lat_class)
      LAT_LOAD:  issue_lat = CNT_W'(LOAD_LATENCY);
      LAT_MULTI: issue_lat = CNT_W'(MULTI_LATENCY);
      default:   issue_lat = '0;
    endcase
  end

  // A fresh issue to a register wins over that register's own decrement.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!hold && (i != 0)) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (issue && reg_write && (rd == 5'(i))) cnt_d[i] = issue_lat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    if (uses_rs1 && (rs1 != 5'd0) && (int'(rs1) < NUM_REGS)) busy_rs1 = (cnt_q[rs1] != '0);
    if (uses_rs2 && (rs2 != 5'd0) && (int'(rs2) < NUM_REGS)) busy_rs2 = (cnt_q[rs2] != '0);
  end

endmodule

// File: rtl/riscv_pipeline_interlock.sv
// Hazard/interlock controller: scoreboard data stalls, EX redirect flush and dmem wait freeze.
// Optional PERF_COUNTERS_EN adds stall/flush/freeze event counters.
module riscv_pipeline_interlock
  import riscv_pipeline_interlock_pkg::*;
#(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned MULTI_LATENCY = 3,
  parameter int unsigned CNT_W         = $clog2(max_int(LOAD_LATENCY, MULTI_LATENCY) + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_uses_rs1,
  input  logic        i_id_uses_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_reg_write,
  input  logic [1:0]  i_id_lat_class,
  input  logic        i_id_valid,
  input  logic        i_ex_redirect,
  input  logic        i_mem_req,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  output logic        o_pc_write,
  output logic        o_stall_if_id,
  output logic        o_bubble_ex,
  output logic        o_flush_if_id,
  output logic        o_freeze,
  output logic        o_dmem_req
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count,
  output logic [31:0] o_freeze_cycles
`endif
);

  dmem_fsm_t dm_q;
  logic      dmem_req_q;
  logic      busy_rs1, busy_rs2;
  logic      data_stall, flush, freeze, issue;

  assign data_stall = busy_rs1 | busy_rs2;

  // Freeze holds until the rvalid cycle, which lets the pipeline advance.
  always_comb begin
    unique case (dm_q)
      DM_IDLE: freeze = i_mem_req;
      DM_REQ:  freeze = !(i_dmem_gnt && i_dmem_rvalid);
      DM_WAIT: freeze = !i_dmem_rvalid;
      default: freeze = 1'b0;
    endcase
  end

  assign flush = i_ex_redirect & ~freeze;
  assign issue = i_id_valid & ~data_stall & ~freeze & ~flush;

  assign o_freeze      = freeze;
  assign o_flush_if_id = flush;
  assign o_bubble_ex   = ~freeze & (flush | data_stall);
  assign o_stall_if_id = ~freeze & ~flush & data_stall;
  assign o_pc_write    = ~freeze & (flush | ~data_stall);
  assign o_dmem_req    = dmem_req_q;

  riscv_scoreboard #(
    .NUM_REGS      (NUM_REGS),
    .LOAD_LATENCY  (LOAD_LATENCY),
    .MULTI_LATENCY (MULTI_LATENCY),
    .CNT_W         (CNT_W)
  ) u_scoreboard (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .hold      (freeze),
    .issue     (issue),
    .reg_write (i_id_reg_write),
    .rd        (i_id_rd),
    .lat_class (lat_class_t'(i_id_lat_class)),
    .rs1       (i_id_rs1),
    .rs2       (i_id_rs2),
    .uses_rs1  (i_id_uses_rs1),
    .uses_rs2  (i_id_uses_rs2),
    .busy_rs1  (busy_rs1),
    .busy_rs2  (busy_rs2)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dm_q       <= DM_IDLE;
      dmem_req_q <= 1'b0;
    end else begin
      unique case (dm_q)
        DM_IDLE: if (i_mem_req) begin
          dm_q       <= DM_REQ;
          dmem_req_q <= 1'b1;
        end
        DM_REQ: if (i_dmem_gnt) begin
          dm_q       <= i_dmem_rvalid ? DM_IDLE : DM_WAIT;
          dmem_req_q <= 1'b0;
        end
        DM_WAIT: if (i_dmem_rvalid) dm_q <= DM_IDLE;
        default: begin
          dm_q       <= DM_IDLE;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_stall_cycles  <= '0;
      o_flush_count   <= '0;
      o_freeze_cycles <= '0;
    end else begin
      if (o_stall_if_id) o_stall_cycles  <= o_stall_cycles + 32'd1;
      if (flush)         o_flush_count   <= o_flush_count + 32'd1;
      if (freeze)        o_freeze_cycles <= o_freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_pipeline_interlock.sv
// Directed bench for riscv_pipeline_interlock; a second instance runs with LOAD_LATENCY=2.
module tb_riscv_pipeline_interlock;

  logic       clk;
  logic       reset_n;
  logic [4:0] rs1, rs2, rd;
  logic       uses1, uses2, reg_write, id_valid, redirect, mem_req, gnt, rvalid;
  logic [1:0] lat;

  logic pcw1, stall1, bub1, flush1, frz1, dreq1;
  logic pcw2, stall2, bub2, flush2, frz2, dreq2;
  logic [5:0] obs1;

  int checks;
  int failures;

  localparam logic [5:0] IDLE_OK    = 6'b100000;
  localparam logic [5:0] STALL      = 6'b011000;
  localparam logic [5:0] FLUSH      = 6'b101100;
  localparam logic [5:0] FREEZE     = 6'b000010;
  localparam logic [5:0] FREEZE_REQ = 6'b000011;

  assign obs1 = {pcw1, stall1, bub1, flush1, frz1, dreq1};

`ifdef PERF_COUNTERS_EN
  logic [31:0] sc1, fc1, zc1, sc2, fc2, zc2;
`endif

  riscv_pipeline_interlock dut (
    .i_clk (clk), .i_reset_n (reset_n),
    .i_id_rs1 (rs1), .i_id_rs2 (rs2), .i_id_uses_rs1 (uses1), .i_id_uses_rs2 (uses2),
    .i_id_rd (rd), .i_id_reg_write (reg_write), .i_id_lat_class (lat), .i_id_valid (id_valid),
    .i_ex_redirect (redirect), .i_mem_req (mem_req), .i_dmem_gnt (gnt), .i_dmem_rvalid (rvalid),
    .o_pc_write (pcw1), .o_stall_if_id (stall1), .o_bubble_ex (bub1),
    .o_flush_if_id (flush1), .o_freeze (frz1), .o_dmem_req (dreq1)
`ifdef PERF_COUNTERS_EN
    , .o_stall_cycles (sc1), .o_flush_count (fc1), .o_freeze_cycles (zc1)
`endif
  );

  riscv_pipeline_interlock #(.LOAD_LATENCY (2)) dut2 (
    .i_clk (clk), .i_reset_n (reset_n),
    .i_id_rs1 (rs1), .i_id_rs2 (rs2), .i_id_uses_rs1 (uses1), .i_id_uses_rs2 (uses2),
    .i_id_rd (rd), .i_id_reg_write (reg_write), .i_id_lat_class (lat), .i_id_valid (id_valid),
    .i_ex_redirect (redirect), .i_mem_req (mem_req), .i_dmem_gnt (gnt), .i_dmem_rvalid (rvalid),
    .o_pc_write (pcw2), .o_stall_if_id (stall2), .o_bubble_ex (bub2),
    .o_flush_if_id (flush2), .o_freeze (frz2), .o_dmem_req (dreq2)
`ifdef PERF_COUNTERS_EN
    , .o_stall_cycles (sc2), .o_flush_count (fc2), .o_freeze_cycles (zc2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; uses1 = 1'b0; uses2 = 1'b0; rd = 5'd0; reg_write = 1'b0;
    lat = 2'd0; id_valid = 1'b0; redirect = 1'b0; mem_req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic set_instr(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                           input logic u2, input logic [4:0] d, input logic w,
                           input logic [1:0] c);
    rs1 = s1; uses1 = u1; rs2 = s2; uses2 = u2; rd = d; reg_write = w; lat = c; id_valid = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", obs1, IDLE_OK);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL post_reset_outputs got=%b want=%b", obs1, IDLE_OK);
    end
  endtask

  task automatic test_load_use();
    logic [5:0] exp1 [3];
    logic       exp2 [3];
    exp1[0] = STALL;   exp2[0] = 1'b1;
    exp1[1] = IDLE_OK; exp2[1] = 1'b1;
    exp1[2] = IDLE_OK; exp2[2] = 1'b0;
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
    #2;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL load_issue got=%b want=%b", obs1, IDLE_OK);
    end
    step();
    set_instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (obs1 !== exp1[k]) begin
        failures++;
        $display("FAIL load_use_lat1 cycle=%0d got=%b want=%b", k, obs1, exp1[k]);
      end
      checks++;
      if (stall2 !== exp2[k]) begin
        failures++;
        $display("FAIL load_use_lat2 cycle=%0d got=%b want=%b", k, stall2, exp2[k]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_multi();
    logic [5:0] exp [4];
    exp[0] = STALL; exp[1] = STALL; exp[2] = STALL; exp[3] = IDLE_OK;
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
    step();
    set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++;
      if (obs1 !== exp[k]) begin
        failures++;
        $display("FAIL multi_consumer cycle=%0d got=%b want=%b", k, obs1, exp[k]);
      end
      step();
    end
    drain();
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
    step();
    set_instr(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    #2;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL multi_independent got=%b want=%b", obs1, IDLE_OK);
    end
    step();
    drain();
  endtask

  task automatic test_x0();
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1);
    step();
    set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0);
    #2;
    checks++;
    if ({obs1, stall2} !== {IDLE_OK, 1'b0}) begin
      failures++;
      $display("FAIL x0_no_stall got=%b/%b want=%b/0", obs1, stall2, IDLE_OK);
    end
    step();
    drain();
  endtask

  task automatic test_redirect_over_stall();
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
    step();
    set_instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
    redirect = 1'b1;
    #2;
    checks++;
    if (obs1 !== FLUSH) begin
      failures++;
      $display("FAIL redirect_flush got=%b want=%b", obs1, FLUSH);
    end
    step();
    redirect = 1'b0;
    set_instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    #2;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL squashed_rd_busy got=%b want=%b", obs1, IDLE_OK);
    end
    step();
    drain();
  endtask

  task automatic test_mem_freeze();
    logic [5:0] exp [9];
    exp[0] = FREEZE;     exp[1] = FREEZE_REQ; exp[2] = FREEZE_REQ;
    exp[3] = FREEZE;     exp[4] = FREEZE;     exp[5] = STALL;
    exp[6] = STALL;      exp[7] = STALL;      exp[8] = IDLE_OK;
    set_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
    step();
    set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    for (int k = 0; k < 9; k++) begin
      mem_req = (k < 3);
      gnt     = (k == 2);
      rvalid  = (k == 5);
      #2;
      checks++;
      if (obs1 !== exp[k]) begin
        failures++;
        $display("FAIL mem_freeze cycle=%0d got=%b want=%b", k, obs1, exp[k]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_redirect_in_freeze();
    logic [5:0] exp [3];
    exp[0] = FREEZE; exp[1] = 6'b101101; exp[2] = IDLE_OK;
    for (int k = 0; k < 3; k++) begin
      mem_req  = (k == 0);
      redirect = (k < 2);
      gnt      = (k == 1);
      rvalid   = (k == 1);
      #2;
      checks++;
      if (obs1 !== exp[k]) begin
        failures++;
        $display("FAIL redirect_in_freeze cycle=%0d got=%b want=%b", k, obs1, exp[k]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid_access();
    mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    gnt     = 1'b1;
    step();
    gnt = 1'b0;
    #2;
    checks++;
    if (obs1 !== FREEZE) begin
      failures++;
      $display("FAIL wait_state got=%b want=%b", obs1, FREEZE);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL async_reset_idle got=%b want=%b", obs1, IDLE_OK);
    end
`ifdef PERF_COUNTERS_EN
    checks++;
    if ({sc1, fc1, zc1} !== 96'd0) begin
      failures++;
      $display("FAIL perf_reset got=%0d/%0d/%0d want=0/0/0", sc1, fc1, zc1);
    end
`endif
    step();
    reset_n = 1'b1;
    step();
    rvalid = 1'b1;
    #2;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL late_rvalid got=%b want=%b", obs1, IDLE_OK);
    end
    step();
    rvalid = 1'b0;
    #2;
    checks++;
    if (obs1 !== IDLE_OK) begin
      failures++;
      $display("FAIL after_late_rvalid got=%b want=%b", obs1, IDLE_OK);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_load_use();
    test_multi();
    test_x0();
    test_redirect_over_stall();
    test_mem_freeze();
    test_redirect_in_freeze();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
